serial_frame_transmitter: RTL and testbench

SERIAL_FRAME_TRANSMITTER -- requirements
Module: serial_frame_transmitter

---
 rtl/serial_frame_transmitter_pkg.sv | 27 ++
 rtl/serial_frame_transmitter_if.sv | 28 ++
 rtl/serial_frame_transmitter_address_counter.sv | 33 +++
 rtl/serial_frame_transmitter.sv | 194 +++++++++++++++++++
 tb/tb_serial_frame_transmitter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared types and constants for the serial frame transmitter.
//   state_t     : transmitter FSM states
//   DEFAULT_LEN : default maximum payload length in bytes
// Macro SERIAL_TX_CHECKSUM_EN adds the CHECKSUM state to the enum.
// -----------------------------------------------------------------------------
package serial_pkg;

  localparam int DEFAULT_LEN = 32;

  typedef enum logic [3:0] {
    IDLE,
    HEADER,
    STATUS,
    FETCH,
    LOAD,
    PAYLOAD,
`ifdef SERIAL_TX_CHECKSUM_EN
    CHECKSUM,
`endif
    GUARD,
    WAIT,
    END
  } state_t;

endpackage

// File: rtl/serial_frame_transmitter_if.sv
// -----------------------------------------------------------------------------
// serial_frame_transmitter_if
// Payload RAM read port plus UART byte handshake.
//   ram_address_o : RAM read address (transmitter -> RAM)
//   ram_i         : RAM read data, one cycle after the address
//   tx_busy_i     : UART busy
//   new_tx_data_o : one-cycle strobe handing tx_data_o to the UART
//   tx_data_o     : byte to send, held between strobes
// -----------------------------------------------------------------------------
interface serial_frame_transmitter_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ram_address_o;
  logic [7:0]        ram_i;
  logic              tx_busy_i;
  logic              new_tx_data_o;
  logic [7:0]        tx_data_o;

  modport master (
    output ram_address_o, new_tx_data_o, tx_data_o,
    input  ram_i, tx_busy_i
  );

  modport slave (
    input  ram_address_o, new_tx_data_o, tx_data_o,
    output ram_i, tx_busy_i
  );
endinterface

// File: rtl/serial_frame_transmitter_address_counter.sv
// -----------------------------------------------------------------------------
// address_counter
// Payload RAM address counter with synchronous clear and increment.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear to 0 (priority over inc_i)
//   inc_i  : increment by one
//   addr_o : current address
// -----------------------------------------------------------------------------
module address_counter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o
);
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr_i)      addr_d = '0;
    else if (inc_i) addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr_o = addr_q;
endmodule

// File: rtl/serial_frame_transmitter.sv
// -----------------------------------------------------------------------------
// serial_frame_transmitter
// Sends a frame of header, status and N payload bytes (read from a RAM with
// one-cycle read latency) over a busy/strobe UART handshake.
// With SERIAL_TX_CHECKSUM_EN defined, a mod-256 sum of all bytes is appended.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   transmit_i        : level start request, sampled only in IDLE
//   length_i          : payload count; 0 or > MAX_LEN means MAX_LEN
//   header_byte_i     : first frame byte
//   status_byte_i     : second frame byte
//   bus               : RAM read port and UART handshake (master side)
//   busy_o            : frame in progress
//   done_o            : one-cycle completion pulse
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for transmit_i
// HEADER   | send header byte when UART free
// STATUS   | send status byte when UART free
// FETCH    | address presented to RAM
// LOAD     | RAM data captured
// PAYLOAD  | send captured payload byte when UART free
// CHECKSUM | send running sum (checksum build only)
// GUARD    | ignore tx_busy_i for GUARD_CYCLES after a strobe
// WAIT     | wait for UART idle, then go to the byte state held in ret_q
// END      | pulse done_o, drop busy_o
// -----------------------------------------------------------------------------
module serial_frame_transmitter
  import serial_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int MAX_LEN      = DEFAULT_LEN,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       transmit_i,
  input  logic [ADDR_W:0]            length_i,
  input  logic [7:0]                 header_byte_i,
  input  logic [7:0]                 status_byte_i,
  serial_frame_transmitter_if.master bus,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int                LEN_W      = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [1:0]        GUARD_LAST = 2'(GUARD_CYCLES - 1);

  state_t            state_q, state_d, ret_q, ret_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        hdr_q, hdr_d, sts_q, sts_d, byte_q, byte_d, tx_q, tx_d;
  logic              strobe_q, strobe_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]        guard_q, guard_d;
  logic              addr_clr, addr_inc, send;
  logic [7:0]        send_byte;
  logic [ADDR_W-1:0] addr;
`ifdef SERIAL_TX_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  address_counter #(.ADDR_W(ADDR_W)) u_addr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (addr_clr),
    .inc_i  (addr_inc),
    .addr_o (addr)
  );

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    len_d     = len_q;
    hdr_d     = hdr_q;
    sts_d     = sts_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    strobe_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    guard_d   = guard_q;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    send      = 1'b0;
    send_byte = tx_q;
`ifdef SERIAL_TX_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      IDLE: if (transmit_i) begin
        len_d    = (length_i == '0 || length_i > MAX_LEN_L) ? MAX_LEN_L : length_i;
        hdr_d    = header_byte_i;
        sts_d    = status_byte_i;
        addr_clr = 1'b1;
        busy_d   = 1'b1;
        state_d  = HEADER;
`ifdef SERIAL_TX_CHECKSUM_EN
        sum_d    = '0;
`endif
      end
      HEADER: if (!bus.tx_busy_i) begin
        send = 1'b1; send_byte = hdr_q; ret_d = STATUS;
      end
      STATUS: if (!bus.tx_busy_i) begin
        send = 1'b1; send_byte = sts_q; ret_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        byte_d  = bus.ram_i;
        state_d = PAYLOAD;
      end
      PAYLOAD: if (!bus.tx_busy_i) begin
        send      = 1'b1;
        send_byte = byte_q;
        // Last byte leaves the address in place so a full-depth frame never wraps.
        if ({1'b0, addr} == len_q - 1'b1) begin
`ifdef SERIAL_TX_CHECKSUM_EN
          ret_d = CHECKSUM;
`else
          ret_d = END;
`endif
        end else begin
          ret_d    = FETCH;
          addr_inc = 1'b1;
        end
      end
`ifdef SERIAL_TX_CHECKSUM_EN
      CHECKSUM: if (!bus.tx_busy_i) begin
        send = 1'b1; send_byte = sum_q; ret_d = END;
      end
`endif
      GUARD: begin
        if (guard_q == '0) state_d = WAIT;
        else               guard_d = guard_q - 1'b1;
      end
      WAIT: if (!bus.tx_busy_i) state_d = ret_q;
      END: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (send) begin
      strobe_d = 1'b1;
      tx_d     = send_byte;
      guard_d  = GUARD_LAST;
      state_d  = GUARD;
`ifdef SERIAL_TX_CHECKSUM_EN
      sum_d    = sum_q + send_byte;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ret_q    <= IDLE;
      len_q    <= '0;
      hdr_q    <= '0;
      sts_q    <= '0;
      byte_q   <= '0;
      tx_q     <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      guard_q  <= '0;
`ifdef SERIAL_TX_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      len_q    <= len_d;
      hdr_q    <= hdr_d;
      sts_q    <= sts_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      guard_q  <= guard_d;
`ifdef SERIAL_TX_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign bus.ram_address_o = addr;
  assign bus.tx_data_o     = tx_q;
  assign bus.new_tx_data_o = strobe_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Bench for serial_frame_transmitter; honours SERIAL_TX_CHECKSUM_EN.
module tb_serial_frame_transmitter;
  localparam int ADDR_W  = 5;
  localparam int MAX_LEN = 32;

  logic             clk, rst, transmit, busy, done;
  logic [ADDR_W:0]  length;
  logic [7:0]       header_byte, status_byte;
  logic [7:0]       mem [0:MAX_LEN-1];
  logic [7:0]       got_q[$];
  logic [7:0]       exp_q[$];
  int               checks, errors, done_cnt, max_addr;
  int               uart_len, uart_delay, u_cnt, u_dly;
  bit               force_busy;

  serial_frame_transmitter_if #(.ADDR_W(ADDR_W)) bus ();

  serial_frame_transmitter #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .GUARD_CYCLES(1)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .transmit_i    (transmit),
    .length_i      (length),
    .header_byte_i (header_byte),
    .status_byte_i (status_byte),
    .bus           (bus),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM
  always @(posedge clk) bus.ram_i <= mem[bus.ram_address_o];

  // UART: busy for uart_len cycles, starting uart_delay cycles after a strobe
  initial begin
    u_cnt = 0; u_dly = 0; bus.tx_busy_i = 1'b0;
  end
  always @(negedge clk) begin
    if (bus.new_tx_data_o) begin u_dly = uart_delay; u_cnt = uart_len; end
    else if (u_dly > 0)    u_dly--;
    else if (u_cnt > 0)    u_cnt--;
    bus.tx_busy_i = force_busy || (u_dly == 0 && u_cnt > 0);
  end

  // Monitor
  always @(negedge clk) begin
    if (bus.new_tx_data_o) got_q.push_back(bus.tx_data_o);
    if (done) done_cnt++;
    if (busy && int'(bus.ram_address_o) > max_addr) max_addr = int'(bus.ram_address_o);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: frame = header, status, mem[0..N-1] (+ mod-256 sum)
  function automatic void build_expected(input logic [7:0] h, input logic [7:0] s, input int l);
    int n, sum;
    n = (l == 0 || l > MAX_LEN) ? MAX_LEN : l;
    exp_q.push_back(h);
    exp_q.push_back(s);
    sum = int'(h) + int'(s);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[i]);
      sum += int'(mem[i]);
    end
`ifdef SERIAL_TX_CHECKSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
  endfunction

  task automatic clear_obs();
    got_q.delete(); exp_q.delete(); done_cnt = 0; max_addr = 0;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < MAX_LEN; i++) mem[i] = 8'($urandom);
  endtask

  // Called at a negedge; leaves the bench at the next negedge.
  task automatic start_frame(input string tag, input logic [7:0] h, input logic [7:0] s, input int l);
    build_expected(h, s, l);
    header_byte = h; status_byte = s; length = (ADDR_W+1)'(l); transmit = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
    check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < budget);
    check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int n_done);
    check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), {24'b0, got_q[i]}, {24'b0, exp_q[i]});
    check({tag, "_ndone"}, 32'(done_cnt), 32'(n_done));
    check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n, nd;
    logic [7:0] h, s;
    checks = 0; errors = 0; done_cnt = 0; max_addr = 0;
    force_busy = 1'b0; uart_len = 1; uart_delay = 0;
    rst = 1'b1; transmit = 1'b1; length = '0; header_byte = '0; status_byte = '0;
    for (int i = 0; i < MAX_LEN; i++) mem[i] = '0;

    // Reset, with transmit_i high to show reset priority
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_done",   {31'b0, done}, 32'd0);
    check("rst_strobe", {31'b0, bus.new_tx_data_o}, 32'd0);
    check("rst_txdata", {24'b0, bus.tx_data_o}, 32'd0);
    check("rst_addr",   32'(bus.ram_address_o), 32'd0);
    rst = 1'b0; transmit = 1'b0;
    @(negedge clk);

    // Directed 4-byte frame, UART busy 10 cycles per byte
    clear_obs();
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
    uart_len = 10;
    start_frame("t1", 8'hA5, 8'h01, 4);
    wait_done("t1", 600);
    check_frame("t1", 1);
`ifdef SERIAL_TX_CHECKSUM_EN
    if (got_q.size() > 6) check("t1_sum_const", {24'b0, got_q[6]}, 32'h46);
`endif

    // length 0 -> MAX_LEN, no wrap
    clear_obs(); randomize_mem(); uart_len = 1;
    start_frame("t2", 8'($urandom), 8'($urandom), 0);
    wait_done("t2", 2000);
    check_frame("t2", 1);
    check("t2_last_addr", 32'(bus.ram_address_o), 32'(MAX_LEN - 1));
    check("t2_max_addr",  32'(max_addr), 32'(MAX_LEN - 1));

    // UART busy at start for 50 cycles
    clear_obs(); randomize_mem(); uart_len = 2;
    force_busy = 1'b1;
    @(negedge clk);
    h = 8'($urandom);
    start_frame("t3", h, 8'($urandom), 3);
    repeat (50) @(negedge clk);
    check("t3_no_strobe", 32'(got_q.size()), 32'd0);
    check("t3_busy_hold", {31'b0, busy}, 32'd1);
    @(posedge clk); #1 force_busy = 1'b0;
    @(negedge clk);
    check("t3_pre_strobe", {31'b0, bus.new_tx_data_o}, 32'd0);
    @(negedge clk);
    check("t3_hdr_strobe", {31'b0, bus.new_tx_data_o}, 32'd1);
    check("t3_hdr_data",   {24'b0, bus.tx_data_o}, {24'b0, h});
    wait_done("t3", 600);
    check_frame("t3", 1);

    // Reset during the third payload byte
    clear_obs(); randomize_mem(); uart_len = 3;
    start_frame("t4", 8'($urandom), 8'($urandom), 6);
    n = 0;
    while (got_q.size() < 5 && n < 500) begin @(negedge clk); n++; end
    check("t4_reach_p2", 32'(got_q.size()), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("t4_busy",   {31'b0, busy}, 32'd0);
    check("t4_addr",   32'(bus.ram_address_o), 32'd0);
    check("t4_strobe", {31'b0, bus.new_tx_data_o}, 32'd0);
    check("t4_txdata", {24'b0, bus.tx_data_o}, 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t4_no_more_bytes", 32'(got_q.size()), 32'd5);
    check("t4_no_done",       32'(done_cnt), 32'd0);
    clear_obs(); randomize_mem();
    start_frame("t4b", 8'($urandom), 8'($urandom), $urandom_range(1, 40));
    wait_done("t4b", 2000);
    check_frame("t4b", 1);

    // transmit_i held for two back-to-back frames
    clear_obs(); randomize_mem(); uart_len = 2;
    h = 8'($urandom); s = 8'($urandom); n = $urandom_range(1, 8);
    build_expected(h, s, n);
    build_expected(h, s, n);
    header_byte = h; status_byte = s; length = (ADDR_W+1)'(n); transmit = 1'b1;
    n = 0; nd = 0;
    while (nd < 2 && n < 3000) begin
      @(negedge clk); n++;
      if (done) nd++;
    end
    transmit = 1'b0;
    check("t5_two_done", 32'(nd), 32'd2);
    repeat (20) @(negedge clk);
    check_frame("t5", 2);

    // transmit_i pulsed mid-frame is ignored
    clear_obs(); randomize_mem();
    h = 8'($urandom);
    start_frame("t6", h, 8'($urandom), 8);
    n = 0;
    while (got_q.size() < 3 && n < 500) begin @(negedge clk); n++; end
    header_byte = ~h; length = 6'd2; transmit = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
    wait_done("t6", 1000);
    repeat (10) @(negedge clk);
    check_frame("t6", 1);

    // UART raises busy one cycle after the strobe
    clear_obs(); randomize_mem(); uart_len = 1; uart_delay = 1;
    start_frame("t7", 8'($urandom), 8'($urandom), $urandom_range(3, 10));
    wait_done("t7", 1000);
    check_frame("t7", 1);

    // Random frames
    for (int k = 0; k < 5; k++) begin
      clear_obs(); randomize_mem();
      uart_len = $urandom_range(1, 4); uart_delay = $urandom_range(0, 1);
      start_frame($sformatf("r%0d", k), 8'($urandom), 8'($urandom), $urandom_range(0, 63));
      wait_done($sformatf("r%0d", k), 3000);
      check_frame($sformatf("r%0d", k), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
